// File: rtl/is_nop.sv
// MIPS32 canonical-NOP detector: combinational flag plus registered
// per-sample statistics (last flag, NOP count, current and longest run).
module is_nop #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned CNT_LEN  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DATA_LEN-1:0] i_opp,
    input  logic                i_valid,
    input  logic                i_clr,
    output logic                o_is_nop,
    output logic                o_is_nop_q,
    output logic [CNT_LEN-1:0]  o_nop_cnt,
    output logic [CNT_LEN-1:0]  o_nop_run,
    output logic [CNT_LEN-1:0]  o_max_run
);

    logic               w_nop;
    logic [CNT_LEN-1:0] w_cnt_inc;
    logic [CNT_LEN-1:0] w_run_inc;

    logic               r_is_nop_q;
    logic [CNT_LEN-1:0] r_nop_cnt;
    logic [CNT_LEN-1:0] r_nop_run;
    logic [CNT_LEN-1:0] r_max_run;

    assign w_nop = ~|i_opp;

    // Saturating increments: hold at all-ones instead of wrapping.
    always_comb begin
        w_cnt_inc = (&r_nop_cnt) ? r_nop_cnt : r_nop_cnt + CNT_LEN'(1);
        w_run_inc = (&r_nop_run) ? r_nop_run : r_nop_run + CNT_LEN'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_is_nop_q <= 1'b0;
            r_nop_cnt  <= '0;
            r_nop_run  <= '0;
            r_max_run  <= '0;
        end else if (i_clr) begin
            r_is_nop_q <= 1'b0;
            r_nop_cnt  <= '0;
            r_nop_run  <= '0;
            r_max_run  <= '0;
        end else if (i_valid) begin
            r_is_nop_q <= w_nop;
            if (w_nop) begin
                r_nop_cnt <= w_cnt_inc;
                r_nop_run <= w_run_inc;
                if (w_run_inc > r_max_run) begin
                    r_max_run <= w_run_inc;
                end
            end else begin
                r_nop_run <= '0;
            end
        end
    end

    assign o_is_nop   = w_nop;
    assign o_is_nop_q = r_is_nop_q;
    assign o_nop_cnt  = r_nop_cnt;
    assign o_nop_run  = r_nop_run;
    assign o_max_run  = r_max_run;

endmodule

// File: tb/tb_is_nop.sv
// Bench for is_nop: default-width and 4-bit-counter instances on shared
// stimulus, checked every cycle against a count-based model plus literals.
module tb_is_nop;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n;
    logic [31:0] opp = '0;
    logic        valid = 1'b0;
    logic        clr = 1'b0;

    logic        nop_a, nopq_a;
    logic [15:0] cnt_a, run_a, max_a;
    logic        nop_b, nopq_b;
    logic [3:0]  cnt_b, run_b, max_b;

    int checks = 0;
    int failures = 0;

    int lim   [2] = '{65535, 15};
    int m_q   [2] = '{0, 0};
    int m_cnt [2] = '{0, 0};
    int m_run [2] = '{0, 0};
    int m_max [2] = '{0, 0};

    is_nop dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_opp(opp), .i_valid(valid), .i_clr(clr),
        .o_is_nop(nop_a), .o_is_nop_q(nopq_a), .o_nop_cnt(cnt_a),
        .o_nop_run(run_a), .o_max_run(max_a)
    );

    is_nop #(.DATA_LEN(32), .CNT_LEN(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_opp(opp), .i_valid(valid), .i_clr(clr),
        .o_is_nop(nop_b), .o_is_nop_q(nopq_b), .o_nop_cnt(cnt_b),
        .o_nop_run(run_b), .o_max_run(max_b)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic int sat_inc(input int v, input int l);
        return (v >= l) ? l : v + 1;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Model: statistics as plain integers following the sampling rules.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || clr) begin
                m_q[k] <= 0; m_cnt[k] <= 0; m_run[k] <= 0; m_max[k] <= 0;
            end else if (valid) begin
                if (opp == 32'd0) begin
                    m_q[k]   <= 1;
                    m_cnt[k] <= sat_inc(m_cnt[k], lim[k]);
                    m_run[k] <= sat_inc(m_run[k], lim[k]);
                    m_max[k] <= imax(m_max[k], sat_inc(m_run[k], lim[k]));
                end else begin
                    m_q[k]   <= 0;
                    m_run[k] <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (clk_en) begin
            check("cyc_is_nop_a", 32'(nop_a), 32'(opp == 32'd0));
            check("cyc_is_nop_b", 32'(nop_b), 32'(opp == 32'd0));
            check("cyc_q_a",   32'(nopq_a), 32'(m_q[0]));
            check("cyc_cnt_a", 32'(cnt_a),  32'(m_cnt[0]));
            check("cyc_run_a", 32'(run_a),  32'(m_run[0]));
            check("cyc_max_a", 32'(max_a),  32'(m_max[0]));
            check("cyc_q_b",   32'(nopq_b), 32'(m_q[1]));
            check("cyc_cnt_b", 32'(cnt_b),  32'(m_cnt[1]));
            check("cyc_run_b", 32'(run_b),  32'(m_run[1]));
            check("cyc_max_b", 32'(max_b),  32'(m_max[1]));
        end
    end

    task automatic step(input logic v, input logic [31:0] o, input logic c);
        valid = v; opp = o; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats_a(input string tag, input int q, input int cnt, input int run, input int mx);
        check({tag, "_q"},   32'(nopq_a), 32'(q));
        check({tag, "_cnt"}, 32'(cnt_a),  32'(cnt));
        check({tag, "_run"}, 32'(run_a),  32'(run));
        check({tag, "_max"}, 32'(max_a),  32'(mx));
    endtask

    initial begin
        logic [31:0] pats [5];
        logic        exps [5];
        pats = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h5555_5555, 32'h8000_0000};
        exps = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        // No clock, reset held: combinational flag only.
        for (int i = 0; i < 5; i++) begin
            opp = pats[i];
            #10;
            check("noclk_is_nop", 32'(nop_a), 32'(exps[i]));
            check("noclk_is_nop4", 32'(nop_b), 32'(exps[i]));
        end
        check_stats_a("rst", 0, 0, 0, 0);

        opp = '0;
        #2 rst_n = 1'b1;
        #2 clk_en = 1'b1;

        step(1, 32'h0, 0); step(1, 32'h0, 0); step(1, 32'h0, 0);
        step(1, 32'h1, 0); step(1, 32'h0, 0);
        check_stats_a("seq", 1, 4, 1, 3);

        step(1, 32'h0, 1);
        check_stats_a("clr", 0, 0, 0, 0);
        check("clr_cnt_b", 32'(cnt_b), 32'd0);

        step(1, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h1, 0);
            check("idle_q", 32'(nopq_a), 32'd1);
        end
        step(1, 32'h0, 0);
        check("idle_run", 32'(run_a), 32'd2);
        check("idle_cnt", 32'(cnt_a), 32'd2);

        step(1, 32'hDEAD_BEEF, 0);
        check_stats_a("brk", 0, 2, 0, 2);
        step(0, 32'h0, 0);
        check_stats_a("hold", 0, 2, 0, 2);

        step(0, 32'h0, 1);
        for (int i = 0; i < 20; i++) step(1, 32'h0, 0);
        check("sat_cnt_b", 32'(cnt_b), 32'd15);
        check("sat_run_b", 32'(run_b), 32'd15);
        check("sat_max_b", 32'(max_b), 32'd15);
        check_stats_a("nosat", 1, 20, 20, 20);
        step(1, 32'h4, 0);
        check("sat_brk_run_b", 32'(run_b), 32'd0);
        check("sat_brk_max_b", 32'(max_b), 32'd15);

        step(0, 32'h0, 1);
        for (int i = 0; i < 5; i++) step(1, 32'h0, 0);
        check("run5", 32'(run_a), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check_stats_a("arst", 0, 0, 0, 0);
        check("arst_cnt_b", 32'(cnt_b), 32'd0);
        opp = 32'h0000_0100;
        #0.5;
        check("arst_is_nop", 32'(nop_a), 32'd0);
        opp = 32'h0;
        #0.5;
        check("arst_is_nop0", 32'(nop_a), 32'd1);
        step(1, 32'h0, 0);
        check_stats_a("inrst", 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        step(1, 32'h0, 0);
        check_stats_a("post", 1, 1, 1, 1);

        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
